ctrl_pipe_decoder: RTL and testbench

Pipelined, parametrised MIPS control decoder for the CPU's decode/execute path. It decodes `{in_special, in_func}` into the control word (IM, ALU mode, ALU input select, register control, syscall) and carries the word through `STAGES` registered stages with valid, stall and flush. A syscall drains the pipe and holds the CPU halted until resumed. It replaces purely combinational decoding wherever the datapath is pipelined.

---
 rtl/ctrl_pipe_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_ctrl_pipe_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined MIPS control decoder with valid/stall/flush and syscall halt FSM.
// Optional: define CTRL_ILLEGAL_TRAP_EN to trap undecoded codes like syscall.
module ctrl_pipe_decoder #(
  parameter int STAGES    = 2,
  parameter int ALUMODE_W = 4,
  parameter int ALUIN_W   = 4,
  parameter int REGCTL_W  = 5
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_valid,
  input  logic                 in_special,
  input  logic [5:0]           in_func,
  input  logic                 in_stall,
  input  logic                 in_flush,
  input  logic                 in_resume,
  output logic                 out_ready,
  output logic                 out_valid,
  output logic                 out_IM,
  output logic [ALUMODE_W-1:0] out_alumode,
  output logic [ALUIN_W-1:0]   out_aluin,
  output logic [REGCTL_W-1:0]  out_regcontrol,
  output logic                 out_syscall,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                 out_illegal,
`endif
  output logic                 out_halt
);

  typedef struct packed {
    logic                 im;
    logic [ALUMODE_W-1:0] alumode;
    logic [ALUIN_W-1:0]   aluin;
    logic [REGCTL_W-1:0]  regctl;
    logic                 sys;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                 ill;
`endif
  } ctrl_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_nxt;

  ctrl_t              r_word [STAGES];
  logic  [STAGES-1:0] r_vld;

  ctrl_t w_dec;
  ctrl_t w_fin;
  logic  w_acc;
  logic  w_trap;
  logic  w_fin_trap;

  function automatic ctrl_t mk(
    input logic       im,
    input logic [3:0] am,
    input logic [3:0] ai,
    input logic [4:0] rc,
    input logic       sc
  );
    ctrl_t w;
    w         = '0;
    w.im      = im;
    w.alumode = ALUMODE_W'(am);
    w.aluin   = ALUIN_W'(ai);
    w.regctl  = REGCTL_W'(rc);
    w.sys     = sc;
    return w;
  endfunction

  // Undecoded codes: a NOP, tagged illegal when trapping is built in.
  function automatic ctrl_t undec();
    ctrl_t w;
    w = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w.ill = 1'b1;
`endif
    return w;
  endfunction

  always_comb begin
    w_dec = '0;
    if (in_special) begin
      unique case (in_func)
        6'b100000,
        6'b100001:
          w_dec = mk(1'b0, 4'b0101, 4'b0010, 5'b01101, 1'b0);
        6'b100010:
          w_dec = mk(1'b0, 4'b0110, 4'b0010, 5'b01101, 1'b0);
        6'b100100:
          w_dec = mk(1'b0, 4'b0111, 4'b0010, 5'b01101, 1'b0);
        6'b100101:
          w_dec = mk(1'b0, 4'b1000, 4'b0010, 5'b01101, 1'b0);
        6'b100110:
          w_dec = mk(1'b0, 4'b1001, 4'b0010, 5'b01101, 1'b0);
        6'b100111:
          w_dec = mk(1'b0, 4'b1010, 4'b0010, 5'b01101, 1'b0);
        6'b101010,
        6'b101011:
          w_dec = mk(1'b0, 4'b1011, 4'b0010, 5'b01101, 1'b0);
        6'b000000:
          w_dec = mk(1'b0, 4'b0000, 4'b1000, 5'b01101, 1'b0);
        6'b000010:
          w_dec = mk(1'b0, 4'b0010, 4'b1000, 5'b01101, 1'b0);
        6'b000011:
          w_dec = mk(1'b0, 4'b0001, 4'b1000, 5'b01101, 1'b0);
        6'b000110:
          w_dec = mk(1'b0, 4'b0010, 4'b1100, 5'b01101, 1'b0);
        6'b001000:
          w_dec = mk(1'b0, 4'b0000, 4'b0000, 5'b00000, 1'b0);
        6'b001100:
          w_dec = mk(1'b0, 4'b0000, 4'b0000, 5'b00000, 1'b1);
        default:
          w_dec = undec();
      endcase
    end else begin
      unique case (in_func)
        6'b001000:
          w_dec = mk(1'b1, 4'b0101, 4'b0001, 5'b01110, 1'b0);
        6'b001001:
          w_dec = mk(1'b0, 4'b0101, 4'b0001, 5'b01110, 1'b0);
        6'b001100:
          w_dec = mk(1'b0, 4'b0111, 4'b0001, 5'b01110, 1'b0);
        6'b001101:
          w_dec = mk(1'b0, 4'b1000, 4'b0001, 5'b01110, 1'b0);
        6'b001010:
          w_dec = mk(1'b1, 4'b1011, 4'b0010, 5'b01110, 1'b0);
        6'b000100,
        6'b000101:
          w_dec = mk(1'b1, 4'b0000, 4'b0010, 5'b00000, 1'b0);
        6'b000001:
          w_dec = mk(1'b1, 4'b1011, 4'b0000, 5'b00000, 1'b0);
        6'b000010:
          w_dec = mk(1'b0, 4'b0000, 4'b0000, 5'b00000, 1'b0);
        6'b000011:
          w_dec = mk(1'b0, 4'b0000, 4'b0000, 5'b00100, 1'b0);
        6'b100011,
        6'b100101:
          w_dec = mk(1'b1, 4'b0101, 4'b0001, 5'b10110, 1'b0);
        6'b101011:
          w_dec = mk(1'b1, 4'b0101, 4'b0001, 5'b00000, 1'b0);
        default:
          w_dec = undec();
      endcase
    end
  end

  assign w_fin = r_word[STAGES-1];

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign w_trap     = w_dec.sys | w_dec.ill;
  assign w_fin_trap = r_vld[STAGES-1] & (w_fin.sys | w_fin.ill);
  assign out_illegal = r_vld[STAGES-1] & w_fin.ill;
`else
  assign w_trap     = w_dec.sys;
  assign w_fin_trap = r_vld[STAGES-1] & w_fin.sys;
`endif

  assign out_ready = (r_state == S_RUN) & ~in_stall & ~in_flush;
  assign w_acc     = in_valid & out_ready;

  // Empty stages always carry a zero word so idle outputs read zero.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++)
        r_word[i] <= '0;
    end else if (in_flush) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++)
        r_word[i] <= '0;
    end else if (!in_stall) begin
      r_vld[0]  <= w_acc;
      r_word[0] <= w_acc ? w_dec : '0;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_word[i] <= r_word[i-1];
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      r_state <= S_RUN;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_RUN:
        if (w_acc && w_trap)
          w_nxt = S_DRAIN;
      S_DRAIN:
        if (in_flush)
          w_nxt = S_RUN;
        else if (w_fin_trap && !in_stall)
          w_nxt = S_HALT;
      S_HALT:
        if (in_resume)
          w_nxt = S_RUN;
      default:
        w_nxt = S_RUN;
    endcase
  end

  assign out_valid      = r_vld[STAGES-1];
  assign out_IM         = w_fin.im;
  assign out_alumode    = w_fin.alumode;
  assign out_aluin      = w_fin.aluin;
  assign out_regcontrol = w_fin.regctl;
  assign out_syscall    = w_fin.sys;
  assign out_halt       = (r_state == S_HALT);

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: queue-based reference model plus
// directed literal checks; works with or without CTRL_ILLEGAL_TRAP_EN.
module tb_ctrl_pipe_decoder;

  localparam int STAGES = 2;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_special = 1'b0;
  logic [5:0] in_func = '0;
  logic       in_stall = 1'b0;
  logic       in_flush = 1'b0;
  logic       in_resume = 1'b0;
  logic       out_ready, out_valid, out_IM, out_syscall, out_halt;
  logic [3:0] out_alumode, out_aluin;
  logic [4:0] out_regcontrol;
  logic       ill_out;
  logic [14:0] w_out;

  ctrl_pipe_decoder #(
    .STAGES(STAGES), .ALUMODE_W(4), .ALUIN_W(4), .REGCTL_W(5)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid),
    .in_special(in_special), .in_func(in_func),
    .in_stall(in_stall), .in_flush(in_flush),
    .in_resume(in_resume), .out_ready(out_ready),
    .out_valid(out_valid), .out_IM(out_IM),
    .out_alumode(out_alumode), .out_aluin(out_aluin),
    .out_regcontrol(out_regcontrol), .out_syscall(out_syscall),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .out_illegal(ill_out),
`endif
    .out_halt(out_halt)
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign ill_out = 1'b0;
`endif

  assign w_out = {out_IM, out_alumode, out_aluin,
                  out_regcontrol, out_syscall};

  always #5 in_clk = ~in_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [14:0] w;
    int          age;
    bit          trap;
    bit          ill;
  } ent_t;

  ent_t q[$];
  int   mode = 0; // 0 run, 1 drain, 2 halt

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // {known, IM, alumode[4], aluin[4], regctl[5], syscall}
  function automatic logic [15:0] W(input logic im,
      input logic [3:0] am, input logic [3:0] ai,
      input logic [4:0] rc, input logic sc);
    return {1'b1, im, am, ai, rc, sc};
  endfunction

  function automatic logic [15:0] ref_dec(input logic sp,
                                          input logic [5:0] fn);
    logic [6:0] k;
    k = {sp, fn};
    case (k)
      7'b1100000, 7'b1100001: return W(0, 4'd5, 4'd2, 5'd13, 0);
      7'b1100010: return W(0, 4'd6, 4'd2, 5'd13, 0);
      7'b1100100: return W(0, 4'd7, 4'd2, 5'd13, 0);
      7'b1100101: return W(0, 4'd8, 4'd2, 5'd13, 0);
      7'b1100110: return W(0, 4'd9, 4'd2, 5'd13, 0);
      7'b1100111: return W(0, 4'd10, 4'd2, 5'd13, 0);
      7'b1101010, 7'b1101011: return W(0, 4'd11, 4'd2, 5'd13, 0);
      7'b1000000: return W(0, 4'd0, 4'd8, 5'd13, 0);
      7'b1000010: return W(0, 4'd2, 4'd8, 5'd13, 0);
      7'b1000011: return W(0, 4'd1, 4'd8, 5'd13, 0);
      7'b1000110: return W(0, 4'd2, 4'd12, 5'd13, 0);
      7'b1001000: return W(0, 4'd0, 4'd0, 5'd0, 0);
      7'b1001100: return W(0, 4'd0, 4'd0, 5'd0, 1);
      7'b0001000: return W(1, 4'd5, 4'd1, 5'd14, 0);
      7'b0001001: return W(0, 4'd5, 4'd1, 5'd14, 0);
      7'b0001100: return W(0, 4'd7, 4'd1, 5'd14, 0);
      7'b0001101: return W(0, 4'd8, 4'd1, 5'd14, 0);
      7'b0001010: return W(1, 4'd11, 4'd2, 5'd14, 0);
      7'b0000100, 7'b0000101: return W(1, 4'd0, 4'd2, 5'd0, 0);
      7'b0000001: return W(1, 4'd11, 4'd0, 5'd0, 0);
      7'b0000010: return W(0, 4'd0, 4'd0, 5'd0, 0);
      7'b0000011: return W(0, 4'd0, 4'd0, 5'd4, 0);
      7'b0100011, 7'b0100101: return W(1, 4'd5, 4'd1, 5'd22, 0);
      7'b0101011: return W(1, 4'd5, 4'd1, 5'd0, 0);
      default: return 16'h0000;
    endcase
  endfunction

  // Model outputs for the current cycle and per-cycle compare.
  task automatic compare();
    logic        ev;
    logic [14:0] ew;
    logic        ei;
    logic        er;
    ev = 0; ew = '0; ei = 0;
    foreach (q[i])
      if (q[i].age == STAGES - 1) begin
        ev = 1; ew = q[i].w; ei = q[i].ill;
      end
    er = (mode == 0) && !in_stall && !in_flush;
    chk("valid", 32'(out_valid), 32'(ev));
    chk("word", 32'(w_out), 32'(ew));
    chk("halt", 32'(out_halt), 32'(mode == 2));
    chk("ready", 32'(out_ready), 32'(er));
    if (TRAP) chk("illegal", 32'(ill_out), 32'(ei));
  endtask

  task automatic model_edge();
    bit          acc, fin_trap, trapd, known;
    logic [15:0] d;
    ent_t        e;
    acc = in_valid && mode == 0 && !in_stall && !in_flush;
    d = ref_dec(in_special, in_func);
    known = d[15];
    trapd = d[0] || (TRAP && !known);
    fin_trap = 0;
    foreach (q[i])
      if (q[i].age == STAGES - 1 && q[i].trap) fin_trap = 1;
    case (mode)
      0: if (acc && trapd) mode = 1;
      1: if (in_flush) mode = 0;
         else if (fin_trap && !in_stall) mode = 2;
      default: if (in_resume) mode = 0;
    endcase
    if (in_flush) q.delete();
    else if (!in_stall) begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age >= STAGES)
        void'(q.pop_front());
      if (acc) begin
        e.w = d[14:0]; e.age = 0;
        e.trap = trapd; e.ill = TRAP && !known;
        q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input bit v, input bit sp, input logic [5:0] fn,
                     input bit st, input bit fl, input bit rs);
    in_valid = v; in_special = sp; in_func = fn;
    in_stall = st; in_flush = fl; in_resume = rs;
    @(negedge in_clk);
    compare();
    model_edge();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle(); cyc(0, 0, 6'd0, 0, 0, 0); endtask

  task automatic do_reset();
    in_rst = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_halt", 32'(out_halt), 0);
    chk("rst_word", 32'(w_out), 0);
    q.delete();
    mode = 0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;
  endtask

  logic [5:0] rlist [14] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h06, 6'h08};
  logic [5:0] ilist [14] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0a,
    6'h04, 6'h05, 6'h01, 6'h02, 6'h03, 6'h23, 6'h25, 6'h2b, 6'h0c};

  initial begin
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 0);
    chk("rst_hold_halt", 32'(out_halt), 0);
    in_rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(out_ready), 1);
    @(posedge in_clk);
    #1;

    // add: latency STAGES-1 edges after acceptance
    cyc(1, 1, 6'b100000, 0, 0, 0);
    chk("add_lat_v", 32'(out_valid), 0);
    idle();
    chk("add_v", 32'(out_valid), 1);
    chk("add_w", 32'(w_out), 32'(15'b0_0101_0010_01101_0));
    idle();
    chk("add_gone", 32'(out_valid), 0);

    // lw, three stall cycles, ori
    cyc(1, 0, 6'b100011, 0, 0, 0);
    repeat (3) cyc(0, 0, 6'd0, 1, 0, 0);
    chk("lw_held", 32'(out_valid), 0);
    cyc(1, 0, 6'b001101, 0, 0, 0);
    chk("lw_w", 32'(w_out), 32'(15'b1_0101_0001_10110_0));
    idle();
    chk("ori_v", 32'(out_valid), 1);
    chk("ori_w", 32'(w_out), 32'(15'b0_1000_0001_01110_0));
    idle();

    // syscall with valid held high
    cyc(1, 1, 6'b001100, 0, 0, 0);
    chk("drain_ready", 32'(out_ready), 0);
    cyc(1, 1, 6'b100000, 0, 0, 0);
    chk("sys_v", 32'(out_valid), 1);
    chk("sys_bit", 32'(out_syscall), 1);
    cyc(1, 1, 6'b100000, 0, 0, 0);
    chk("halt_up", 32'(out_halt), 1);
    chk("halt_nov", 32'(out_valid), 0);
    cyc(1, 1, 6'b100000, 0, 0, 0);
    cyc(1, 1, 6'b100000, 0, 0, 1);
    chk("resume_halt", 32'(out_halt), 0);
    chk("resume_ready", 32'(out_ready), 1);
    idle();

    // flush in DRAIN with syscall in stage 1
    cyc(1, 1, 6'b001100, 0, 0, 0);
    cyc(0, 0, 6'd0, 0, 1, 0);
    chk("fl_drain_v", 32'(out_valid), 0);
    idle();
    chk("fl_drain_v2", 32'(out_valid), 0);
    chk("fl_drain_halt", 32'(out_halt), 0);
    chk("fl_drain_rdy", 32'(out_ready), 1);

    // flush + stall with two words in flight
    cyc(1, 1, 6'b100000, 0, 0, 0);
    cyc(1, 1, 6'b100010, 0, 0, 0);
    chk("two_inflight", 32'(out_valid), 1);
    cyc(0, 0, 6'd0, 1, 1, 0);
    chk("flst_v", 32'(out_valid), 0);
    idle();
    chk("flst_v2", 32'(out_valid), 0);

    // undecoded opcode 111111
    cyc(1, 0, 6'b111111, 0, 0, 0);
    idle();
    chk("bad_v", 32'(out_valid), 1);
    chk("bad_w", 32'(w_out), 0);
    chk("bad_ill", 32'(ill_out), 32'(TRAP));
    idle();
    chk("bad_halt", 32'(out_halt), 32'(TRAP));
    cyc(0, 0, 6'd0, 0, 0, 1);
    chk("bad_clr", 32'(out_halt), 0);

    // reset mid-operation
    cyc(1, 1, 6'b100100, 0, 0, 0);
    do_reset();
    idle();
    chk("rst_mid_v", 32'(out_valid), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, sp, st, fl, rs;
      logic [5:0] fn;
      v  = $urandom_range(0, 9) < 8;
      sp = $urandom_range(0, 1);
      st = $urandom_range(0, 9) < 2;
      fl = $urandom_range(0, 24) == 0;
      rs = $urandom_range(0, 9) < 3;
      case ($urandom_range(0, 7))
        0: fn = 6'($urandom);
        1: fn = 6'b001100;
        default: fn = sp ? rlist[$urandom_range(0, 13)]
                         : ilist[$urandom_range(0, 13)];
      endcase
      if (fn == 6'b001100 && sp && $urandom_range(0, 3) != 0)
        fn = 6'b100001;
      if ($urandom_range(0, 699) == 0) do_reset();
      else cyc(v, sp, fn, st, fl, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
